// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one 16-bit word per request over a req/rdy handshake into IR and maintains the PC.
// Latency: Fetch sampled at edge N -> MemReq in cycle N+1 -> IRValid in cycle N+2 (plus one per memory wait cycle).
// Backpressure: memory stalls via MemRdy=0 (holds in WAIT); Stall=1 suppresses new fetches only.
//
// Ports:
//   CLK, Reset            clock, asynchronous active-high reset
//   Fetch, Stall          fetch request and fetch inhibit (sampled in IDLE/DONE)
//   PCWrite, PCIn         branch/jump PC load (honoured in IDLE/DONE only)
//   MemReq, MemAddr       memory read request and address (= PC)
//   MemRdy, MemData       memory data valid and instruction word
//   PC, Opcode, Imm       program counter and IR fields (IR[15:12], IR[11:0])
//   IRValid               one-cycle pulse when IR holds a newly fetched instruction
//   Busy                  fetch in progress (REQ or WAIT)
//   FetchErr              one-cycle pulse on timeout abort
//
// Build option: define FETCH_TIMEOUT_EN to abort fetches whose memory never responds
// (TIMEOUT_CYC WAIT cycles). Without it WAIT holds indefinitely and FetchErr is tied low.

module instr_fetch_unit #(
  parameter int unsigned           DATA_W      = 16,
  parameter int unsigned           IMM_W       = 12,
  parameter int unsigned           OP_W        = 4,
  parameter logic [DATA_W-1:0]     PC_RESET    = '0,
  parameter int unsigned           TIMEOUT_CYC = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Fetch,
  input  logic              Stall,
  input  logic              PCWrite,
  input  logic [DATA_W-1:0] PCIn,
  input  logic              MemRdy,
  input  logic [DATA_W-1:0] MemData,
  output logic              MemReq,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] PC,
  output logic [OP_W-1:0]   Opcode,
  output logic [IMM_W-1:0]  Imm,
  output logic              IRValid,
  output logic              Busy,
  output logic              FetchErr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [DATA_W-1:0] PC_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic              timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYC - 1);

  logic [3:0] to_cnt;
  logic       err_q;

  // The counter value after this WAIT cycle would equal TIMEOUT_CYC.
  assign timeout_hit = (state == S_WAIT) && !MemRdy && (to_cnt == TO_LAST);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      to_cnt <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state == S_REQ) begin
        to_cnt <= 4'd0;
      end else if (state == S_WAIT && !MemRdy) begin
        if (timeout_hit) err_q <= 1'b1;
        else             to_cnt <= to_cnt + 4'd1;
      end
    end
  end

  assign FetchErr = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign FetchErr           = 1'b0;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      pc_q  <= PC_RESET;
      ir_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A branch load takes priority; a coincident Fetch is dropped.
          if (PCWrite)               pc_q  <= PCIn;
          else if (Fetch && !Stall)  state <= S_REQ;
        end
        S_REQ, S_WAIT: begin
          // MemRdy on the expiry cycle still captures normally.
          if (MemRdy) begin
            ir_q  <= MemData;
            pc_q  <= pc_q + PC_ONE;
            state <= S_DONE;
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_DONE: begin
          if (PCWrite) begin
            pc_q  <= PCIn;
            state <= S_IDLE;
          end else if (Fetch && !Stall) begin
            state <= S_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly, so MemReq falls as soon as Reset is asserted.
  assign MemReq  = (state == S_REQ) || (state == S_WAIT);
  assign Busy    = MemReq;
  assign IRValid = (state == S_DONE);
  assign MemAddr = pc_q;
  assign PC      = pc_q;
  assign Opcode  = ir_q[DATA_W-1:IMM_W];
  assign Imm     = ir_q[IMM_W-1:0];

endmodule
